// File: rtl/data_memory_ctrl.sv
// Byte-addressed RISC-V data memory with a req/ready/done handshake, optional wait states,
// byte-lane stores, sign/zero-extended loads, and suppression of misaligned or illegal accesses.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           wd,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           rd,
  output logic                  err
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam int         LOW_W   = IDX_W + 2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [LOW_W-1:0]  addr_q;
  logic [31:0]       wd_q;
  logic [31:0]       rd_q;
  logic              err_q;
  logic              perform;

  logic [31:0]       mem [DEPTH];

  // Upper address bits only alias; fold them into a sink so they are visibly ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[ADDR_WIDTH-1:LOW_W];

  // With zero wait states the access happens on the accepting edge, so use the live inputs.
  logic              use_in;
  logic              a_we;
  logic [2:0]        a_f3;
  logic [LOW_W-1:0]  a_addr;
  logic [31:0]       a_wd;
  logic [IDX_W-1:0]  widx;

  assign use_in = (state_q == S_IDLE);
  assign a_we   = use_in ? we                  : we_q;
  assign a_f3   = use_in ? funct3              : f3_q;
  assign a_addr = use_in ? address[LOW_W-1:0]  : addr_q;
  assign a_wd   = use_in ? wd                  : wd_q;
  assign widx   = a_addr[LOW_W-1:2];

  logic        acc_err;
  logic [31:0] rdata;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [3:0]  wr_be;

  assign rdata = mem[widx];
  assign rbyte = rdata[{a_addr[1:0], 3'b000} +: 8];
  assign rhalf = rdata[{a_addr[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    acc_err  = 1'b0;
    load_val = rdata;
    be       = 4'b0000;
    wdata    = a_wd;
    unique case (a_f3)
      F3_B, F3_BU: begin
        load_val = (a_f3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
        be       = 4'b0001 << a_addr[1:0];
        wdata    = {4{a_wd[7:0]}};
        acc_err  = a_we && (a_f3 == F3_BU);
      end
      F3_H, F3_HU: begin
        load_val = (a_f3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
        be       = a_addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{a_wd[15:0]}};
        acc_err  = a_addr[0] || (a_we && (a_f3 == F3_HU));
      end
      F3_W: begin
        be      = 4'b1111;
        acc_err = (a_addr[1:0] != 2'b00);
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Reset must also block the array write, since the array itself ignores rst.
  assign wr_be = be & {4{perform && a_we && !acc_err && !rst}};

  // NOTE: the array has no reset; contents survive rst and only selected lanes are written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    perform = 1'b0;
    unique case (state_q)
      S_IDLE: if (req) begin
        perform = (WAIT_STATES == 0);
        state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt_q == 4'd1) begin
        perform = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req) begin
        we_q   <= we;
        f3_q   <= funct3;
        addr_q <= address[LOW_W-1:0];
        wd_q   <= wd;
        cnt_q  <= WAIT_LD;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (perform) begin
        err_q <= acc_err;
        if (acc_err)    rd_q <= 32'd0;
        else if (!a_we) rd_q <= load_val;
      end
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_RESP);
  assign err   = done && err_q;
  assign rd    = rd_q;

endmodule
